fpga_robots_game_ps2_tx: RTL and testbench

//  Host-to-device transmitter for PS/2 port A. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.

---
 rtl/fpga_robots_game_ps2_tx.sv | 187 ++++++++++++++++++
 tb/tb_fpga_robots_game_ps2_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_robots_game_ps2_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard using the
// request-to-send sequence, driving the open-drain clock/data pins through output enables.
module fpga_robots_game_ps2_tx #(
  parameter int unsigned INHIBIT_TICKS = 18,
  parameter int unsigned TIMEOUT_TICKS = 2500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sixus,
  input  logic [7:0] tx_dat,
  input  logic       tx_stb,
  output logic       tx_rdy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    RELEASE,
    ACK,
    FINISH,
    ERR
  } state_t;

  localparam logic [4:0]  INH_LIMIT = 5'(INHIBIT_TICKS);
  localparam logic [11:0] TO_LIMIT  = 12'(TIMEOUT_TICKS);
  localparam logic [3:0]  STOP_IDX  = 4'd9;

  state_t      state_q, state_d;
  logic [8:0]  shift_q, shift_d;
  logic [4:0]  inh_cnt_q, inh_cnt_d;
  logic [11:0] to_cnt_q, to_cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        clk_meta_q, clk_meta_d;
  logic        clk_s_q, clk_s_d;
  logic        clk_prev_q, clk_prev_d;
  logic        dat_meta_q, dat_meta_d;
  logic        dat_s_q, dat_s_d;
  logic        tx_rdy_q, tx_rdy_d;
  logic        tx_done_q, tx_done_d;
  logic        tx_err_q, tx_err_d;
  logic        clk_oe_q, clk_oe_d;
  logic        dat_oe_q, dat_oe_d;
  logic        fall;
  logic        timed_out;

  assign fall      = clk_prev_q & ~clk_s_q;
  assign timed_out = (to_cnt_q >= TO_LIMIT);

  always_comb begin
    clk_meta_d = ps2_clk_in;
    clk_s_d    = clk_meta_q;
    clk_prev_d = clk_s_q;
    dat_meta_d = ps2_dat_in;
    dat_s_d    = dat_meta_q;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    idx_d     = idx_q;
    dat_oe_d  = dat_oe_q;
    tx_done_d = 1'b0;

    // Timeout counter saturates so a stalled device can never wrap it back below the limit
    if ((state_q == RELEASE || state_q == ACK || state_q == FINISH) &&
        sixus && (to_cnt_q != 12'hfff)) begin
      to_cnt_d = to_cnt_q + 12'd1;
    end

    case (state_q)
      IDLE: begin
        if (tx_stb) begin
          shift_d   = {~^tx_dat, tx_dat};
          inh_cnt_d = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == INH_LIMIT) begin
          state_d = REQ;
        end else if (sixus) begin
          inh_cnt_d = inh_cnt_q + 5'd1;
        end
      end
      REQ: begin
        idx_d    = '0;
        to_cnt_d = '0;
        state_d  = RELEASE;
      end
      RELEASE: begin
        if (timed_out) begin
          state_d = ERR;
        end else if (fall) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == STOP_IDX) begin
            state_d = ACK;
          end else begin
            dat_oe_d = ~shift_q[idx_q];
          end
        end
      end
      ACK: begin
        if (timed_out) begin
          state_d = ERR;
        end else if (fall) begin
          state_d = dat_s_q ? ERR : FINISH;
        end
      end
      FINISH: begin
        if (timed_out) begin
          state_d = ERR;
        end else if (clk_s_q && dat_s_q) begin
          tx_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line enables follow the state being entered so every output is a clean register
    clk_oe_d = (state_d == INHIBIT) || (state_d == REQ);
    if (state_d == REQ) begin
      dat_oe_d = 1'b1;
    end else if (state_d != RELEASE) begin
      dat_oe_d = 1'b0;
    end
    tx_err_d = (state_d == ERR);
    tx_rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      idx_q      <= '0;
      clk_meta_q <= 1'b1;
      clk_s_q    <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_s_q    <= 1'b1;
      tx_rdy_q   <= 1'b1;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      idx_q      <= idx_d;
      clk_meta_q <= clk_meta_d;
      clk_s_q    <= clk_s_d;
      clk_prev_q <= clk_prev_d;
      dat_meta_q <= dat_meta_d;
      dat_s_q    <= dat_s_d;
      tx_rdy_q   <= tx_rdy_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
    end
  end

  assign tx_rdy     = tx_rdy_q;
  assign tx_done    = tx_done_q;
  assign tx_err     = tx_err_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_fpga_robots_game_ps2_tx.sv
// Self-checking bench for the PS/2 host transmitter: a wired-AND keyboard model clocks frames
// out of the DUT and the received line levels are compared with a byte-level frame model.
module tb_fpga_robots_game_ps2_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sixus = 1'b0;
  logic [7:0] tx_dat = 8'h00;
  logic       tx_stb = 1'b0;
  logic       tx_rdy, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_in, ps2_dat_in;
  logic       devClk = 1'b1;
  logic       devDat = 1'b1;

  int checkCount = 0;
  int errorCount = 0;
  int doneSeen = 0;
  int errSeen = 0;
  int bothSeen = 0;

  // Open-drain bus: the line is high only when neither host nor device pulls it low
  assign ps2_clk_in = devClk & ~ps2_clk_oe;
  assign ps2_dat_in = devDat & ~ps2_dat_oe;

  fpga_robots_game_ps2_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sixus      (sixus),
    .tx_dat     (tx_dat),
    .tx_stb     (tx_stb),
    .tx_rdy     (tx_rdy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clk = ~clk;

  // The 6us tick is scaled down to one pulse every 8 clocks to keep the timeout run short
  initial begin
    forever begin
      repeat (7) @(posedge clk);
      #1 sixus = 1'b1;
      @(posedge clk);
      #1 sixus = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (tx_done) doneSeen++;
    if (tx_err) errSeen++;
    if (tx_done && tx_err) bothSeen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Line levels seen by the device on falls 1..10: data LSB first, odd parity, released stop
  function automatic logic [31:0] frameModel(input logic [7:0] b);
    logic [31:0] f;
    int ones;
    f = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = b[i];
      ones = ones + int'(b[i]);
    end
    f[8] = ((ones % 2) == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1 tx_dat = b;
    tx_stb = 1'b1;
    @(posedge clk);
    #1 tx_stb = 1'b0;
    tx_dat = 8'($urandom);
  endtask

  task automatic waitStart(output int ticks, output logic ok);
    logic seen;
    ticks = 0;
    ok = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 4000 && !ok; n++) begin
      @(negedge clk);
      if (ps2_clk_oe) begin
        seen = 1'b1;
        if (sixus) ticks++;
      end else if (seen && ps2_dat_oe) begin
        ok = 1'b1;
      end
    end
  endtask

  task automatic deviceClock(input int n, output logic [31:0] lv);
    lv = '0;
    for (int i = 0; i < n; i++) begin
      repeat (10) @(posedge clk);
      #1 devClk = 1'b0;
      repeat (10) @(posedge clk);
      #1 lv[i] = ps2_dat_in;
      devClk = 1'b1;
    end
  endtask

  task automatic deviceAck(input logic good);
    repeat (10) @(posedge clk);
    #1 devDat = good ? 1'b0 : 1'b1;
    repeat (5) @(posedge clk);
    #1 devClk = 1'b0;
    repeat (10) @(posedge clk);
    #1 devClk = 1'b1;
    repeat (5) @(posedge clk);
    #1 devDat = 1'b1;
  endtask

  task automatic waitResult(input int base, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (doneSeen + errSeen > base) ok = 1'b1;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic runFrame(input logic [7:0] b, input logic good);
    int d0, e0, ticks;
    logic ok;
    logic [31:0] lv;
    d0 = doneSeen;
    e0 = errSeen;
    applyStimulus(b);
    checkOutput("rdy_low_busy", 32'(tx_rdy), 32'd0);
    waitStart(ticks, ok);
    checkOutput("start_seen", 32'(ok), 32'd1);
    checkOutput("inhibit_ticks", ticks, 32'd18);
    deviceClock(10, lv);
    checkOutput($sformatf("frame_%02h", b), lv, frameModel(b));
    deviceAck(good);
    waitResult(d0 + e0, ok);
    checkOutput("result_seen", 32'(ok), 32'd1);
    checkOutput("done_pulses", doneSeen - d0, good ? 32'd1 : 32'd0);
    checkOutput("err_pulses", errSeen - e0, good ? 32'd0 : 32'd1);
    checkOutput("idle_lines", 32'({tx_rdy, ps2_clk_oe, ps2_dat_oe}), 32'b100);
  endtask

  task automatic runTimeout(input logic [7:0] b);
    int d0, e0, ticks, cnt;
    logic ok, sawOe;
    d0 = doneSeen;
    e0 = errSeen;
    cnt = 0;
    applyStimulus(b);
    waitStart(ticks, ok);
    checkOutput("to_start_seen", 32'(ok), 32'd1);
    for (int n = 0; n < 30000; n++) begin
      if (tx_err) break;
      if (sixus) cnt++;
      if (n == 100) begin
        tx_dat = ~b;
        tx_stb = 1'b1;
      end
      if (n == 101) tx_stb = 1'b0;
      @(negedge clk);
    end
    checkOutput("timeout_err_seen", 32'(tx_err), 32'd1);
    checkOutput("timeout_ticks", cnt, 32'd2500);
    sawOe = 1'b0;
    repeat (60) begin
      @(negedge clk);
      sawOe = sawOe | ps2_clk_oe | ps2_dat_oe;
    end
    checkOutput("dropped_stb_idle", 32'(sawOe), 32'd0);
    checkOutput("to_rdy", 32'(tx_rdy), 32'd1);
    checkOutput("to_done_pulses", doneSeen - d0, 32'd0);
    checkOutput("to_err_pulses", errSeen - e0, 32'd1);
  endtask

  task automatic runResetMid();
    int d0, e0, ticks;
    logic ok;
    logic [31:0] lv;
    d0 = doneSeen;
    e0 = errSeen;
    applyStimulus(8'h00);
    waitStart(ticks, ok);
    checkOutput("rst_start_seen", 32'(ok), 32'd1);
    deviceClock(4, lv);
    checkOutput("pre_rst_dat_oe", 32'(ps2_dat_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_rst_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    checkOutput("async_rst_rdy", 32'(tx_rdy), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    checkOutput("rst_no_result", (doneSeen - d0) + (errSeen - e0), 32'd0);
    runFrame(8'($urandom), 1'b1);
  endtask

  initial begin
    $display("[TB] start");
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 checkOutput("reset_outputs", 32'({tx_rdy, tx_done, tx_err, ps2_clk_oe, ps2_dat_oe}), 32'b10000);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    runFrame(8'hED, 1'b1);
    runFrame(8'h00, 1'b1);
    runFrame(8'hFF, 1'b1);
    runFrame(8'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) begin
      runFrame(8'($urandom), ($urandom_range(0, 3) != 0));
    end
    runTimeout(8'($urandom));
    runResetMid();
    checkOutput("never_both", bothSeen, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
